snow64_interrupt_ctrl: RTL and testbench

//  Owns the interrupt state that the group-1 (control flow/interrupt) instrs manipulate: ie, ireta, idsta.

---
 rtl/snow64_interrupt_ctrl_if.sv | 39 +++
 rtl/snow64_interrupt_ctrl.sv | 156 +++++++++++++++
 tb/tb_snow64_interrupt_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/snow64_interrupt_ctrl_if.sv
// Bundle between the interrupt controller, the execute stage and the fetch unit.
// The controller is the slave: it consumes in_* and produces out_*.
interface snow64_interrupt_ctrl_if #(
  parameter int NUM_IRQ     = 4,
  parameter int WIDTH__ADDR = 64
);

  logic [NUM_IRQ-1:0]     in_irq;
  logic                   in_instr_valid;
  logic                   in_is_iog1;
  logic [3:0]             in_oper;
  logic [WIDTH__ADDR-1:0] in_reg_data;
  logic [WIDTH__ADDR-1:0] in_next_pc;
  logic                   in_pipe_idle;

  logic                   out_ie;
  logic [WIDTH__ADDR-1:0] out_ireta;
  logic [WIDTH__ADDR-1:0] out_idsta;
  logic [WIDTH__ADDR-1:0] out_cpy_data;
  logic                   out_stall;
  logic                   out_redirect_valid;
  logic [WIDTH__ADDR-1:0] out_redirect_pc;
  logic [NUM_IRQ-1:0]     out_irq_ack;

  modport slave (
    input  in_irq, in_instr_valid, in_is_iog1, in_oper, in_reg_data,
           in_next_pc, in_pipe_idle,
    output out_ie, out_ireta, out_idsta, out_cpy_data, out_stall,
           out_redirect_valid, out_redirect_pc, out_irq_ack
  );

  modport master (
    output in_irq, in_instr_valid, in_is_iog1, in_oper, in_reg_data,
           in_next_pc, in_pipe_idle,
    input  out_ie, out_ireta, out_idsta, out_cpy_data, out_stall,
           out_redirect_valid, out_redirect_pc, out_irq_ack
  );

endinterface

// File: rtl/snow64_interrupt_ctrl.sv
// Interrupt state (ie/ireta/idsta), group-1 interrupt instruction execution and
// the IDLE -> DRAIN -> VECTOR entry sequence that stalls fetch and redirects the PC.
module snow64_interrupt_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int WIDTH__ADDR = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  snow64_interrupt_ctrl_if.slave bus
);

  localparam logic [3:0] OPER_EI            = 4'd3;
  localparam logic [3:0] OPER_DI            = 4'd4;
  localparam logic [3:0] OPER_RETI          = 4'd5;
  localparam logic [3:0] OPER_CPY_IE_REG    = 4'd6;
  localparam logic [3:0] OPER_CPY_REG_IE    = 4'd7;
  localparam logic [3:0] OPER_CPY_IRETA_REG = 4'd8;
  localparam logic [3:0] OPER_CPY_REG_IRETA = 4'd9;
  localparam logic [3:0] OPER_CPY_IDSTA_REG = 4'd10;
  localparam logic [3:0] OPER_CPY_REG_IDSTA = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    VECTOR
  } state_t;

  state_t                 state_q, state_d;
  logic                   stall_q, stall_d;
  logic                   ie_q, ie_d;
  logic [WIDTH__ADDR-1:0] ireta_q, ireta_d;
  logic [WIDTH__ADDR-1:0] idsta_q, idsta_d;

  logic                   execIog1;
  logic                   isEi, isDi, isReti;
  logic                   isCpyIeW, isCpyIretaW, isCpyIdstaW;
  logic                   isCpyIeR, isCpyIretaR, isCpyIdstaR;
  logic                   ieWriteBlocks;
  logic                   irqAny;
  logic [NUM_IRQ-1:0]     irqLowest;
  logic                   vectorTake;
  logic [WIDTH__ADDR-1:0] alignedData;

  always_comb begin
    execIog1      = bus.in_instr_valid & bus.in_is_iog1;
    isEi          = execIog1 && (bus.in_oper == OPER_EI);
    isDi          = execIog1 && (bus.in_oper == OPER_DI);
    isReti        = execIog1 && (bus.in_oper == OPER_RETI);
    isCpyIeW      = execIog1 && (bus.in_oper == OPER_CPY_IE_REG);
    isCpyIeR      = execIog1 && (bus.in_oper == OPER_CPY_REG_IE);
    isCpyIretaW   = execIog1 && (bus.in_oper == OPER_CPY_IRETA_REG);
    isCpyIretaR   = execIog1 && (bus.in_oper == OPER_CPY_REG_IRETA);
    isCpyIdstaW   = execIog1 && (bus.in_oper == OPER_CPY_IDSTA_REG);
    isCpyIdstaR   = execIog1 && (bus.in_oper == OPER_CPY_REG_IDSTA);
    // Instructions that change ie win over starting (or continuing) an entry.
    ieWriteBlocks = isReti | isDi | isCpyIeW;
    irqAny        = |bus.in_irq;
    irqLowest     = bus.in_irq & (~bus.in_irq + NUM_IRQ'(1));
    vectorTake    = (state_q == VECTOR) && irqAny;
    alignedData   = {bus.in_reg_data[WIDTH__ADDR-1:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    ie_d    = ie_q;
    ireta_d = ireta_q;
    idsta_d = idsta_q;

    if (isEi || isReti) begin
      ie_d = 1'b1;
    end else if (isDi) begin
      ie_d = 1'b0;
    end else if (isCpyIeW) begin
      ie_d = bus.in_reg_data[0];
    end
    if (isCpyIretaW) begin
      ireta_d = alignedData;
    end
    if (isCpyIdstaW) begin
      idsta_d = alignedData;
    end

    case (state_q)
      IDLE: begin
        if (ie_q && irqAny && !ieWriteBlocks) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ieWriteBlocks) begin
          state_d = IDLE;
        end else if (bus.in_pipe_idle) begin
          state_d = VECTOR;
        end
      end
      VECTOR: begin
        state_d = IDLE;
        if (vectorTake) begin
          ireta_d = bus.in_next_pc;
          ie_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      ie_q    <= 1'b0;
      ireta_q <= '0;
      idsta_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      ie_q    <= ie_d;
      ireta_q <= ireta_d;
      idsta_q <= idsta_d;
    end
  end

  // Reads see the value held before this cycle's edge.
  always_comb begin
    bus.out_cpy_data = '0;
    if (isCpyIeR) begin
      bus.out_cpy_data = {{(WIDTH__ADDR-1){1'b0}}, ie_q};
    end else if (isCpyIretaR) begin
      bus.out_cpy_data = ireta_q;
    end else if (isCpyIdstaR) begin
      bus.out_cpy_data = idsta_q;
    end
  end

  always_comb begin
    bus.out_redirect_valid = 1'b0;
    bus.out_redirect_pc    = '0;
    bus.out_irq_ack        = '0;
    if (vectorTake) begin
      bus.out_redirect_valid = 1'b1;
      bus.out_redirect_pc    = idsta_q;
      bus.out_irq_ack        = irqLowest;
    end else if (isReti) begin
      bus.out_redirect_valid = 1'b1;
      bus.out_redirect_pc    = ireta_q;
    end
  end

  assign bus.out_ie    = ie_q;
  assign bus.out_ireta = ireta_q;
  assign bus.out_idsta = idsta_q;
  assign bus.out_stall = stall_q;

endmodule

// File: tb/tb_snow64_interrupt_ctrl.sv
// Self-checking bench for snow64_interrupt_ctrl: a per-cycle vector table checked
// through an expected-value queue, plus a bounded wait on a full interrupt entry.
module tb_snow64_interrupt_ctrl;

  localparam int NUM_IRQ = 4;
  localparam int W       = 64;

  localparam logic [3:0] OP_NOP      = 4'd0;
  localparam logic [3:0] OP_EI       = 4'd3;
  localparam logic [3:0] OP_DI       = 4'd4;
  localparam logic [3:0] OP_RETI     = 4'd5;
  localparam logic [3:0] OP_CIE_W    = 4'd6;
  localparam logic [3:0] OP_CIE_R    = 4'd7;
  localparam logic [3:0] OP_CIRETA_W = 4'd8;
  localparam logic [3:0] OP_CIRETA_R = 4'd9;
  localparam logic [3:0] OP_CIDSTA_W = 4'd10;
  localparam logic [3:0] OP_CIDSTA_R = 4'd11;

  typedef struct {
    string        name;
    logic         ie;
    logic [63:0]  ireta;
    logic [63:0]  idsta;
    logic [63:0]  cpy;
    logic         stall;
    logic         rv;
    logic [63:0]  rpc;
    logic [3:0]   ack;
  } exp_t;

  typedef struct {
    logic         rstN;
    logic         valid;
    logic         iog1;
    logic [3:0]   oper;
    logic [63:0]  regData;
    logic [63:0]  nextPc;
    logic         pipeIdle;
    logic [3:0]   irq;
    exp_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snow64_interrupt_ctrl_if #(.NUM_IRQ(NUM_IRQ), .WIDTH__ADDR(W)) bus ();

  snow64_interrupt_ctrl #(.NUM_IRQ(NUM_IRQ), .WIDTH__ADDR(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   nCompared = 0;
  int   nMismatched = 0;
  exp_t expQ[$];
  vec_t vecs[$];

  function automatic vec_t mkVec(string name, logic rstN, logic valid, logic iog1,
                                 logic [3:0] oper, logic [63:0] regData,
                                 logic [63:0] nextPc, logic pipeIdle, logic [3:0] irq,
                                 logic eIe, logic [63:0] eIreta, logic [63:0] eIdsta,
                                 logic [63:0] eCpy, logic eStall, logic eRv,
                                 logic [63:0] eRpc, logic [3:0] eAck);
    vec_t v;
    v.rstN = rstN; v.valid = valid; v.iog1 = iog1; v.oper = oper;
    v.regData = regData; v.nextPc = nextPc; v.pipeIdle = pipeIdle; v.irq = irq;
    v.e.name = name; v.e.ie = eIe; v.e.ireta = eIreta; v.e.idsta = eIdsta;
    v.e.cpy = eCpy; v.e.stall = eStall; v.e.rv = eRv; v.e.rpc = eRpc; v.e.ack = eAck;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] want);
    nCompared++;
    if (act !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n              = v.rstN;
    bus.in_instr_valid = v.valid;
    bus.in_is_iog1     = v.iog1;
    bus.in_oper        = v.oper;
    bus.in_reg_data    = v.regData;
    bus.in_next_pc     = v.nextPc;
    bus.in_pipe_idle   = v.pipeIdle;
    bus.in_irq         = v.irq;
    expQ.push_back(v.e);
  endtask

  task automatic checkOutput();
    exp_t e;
    #1;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = expQ.pop_front();
    cmp({e.name, ".ie"},    64'(bus.out_ie),             64'(e.ie));
    cmp({e.name, ".ireta"}, bus.out_ireta,               e.ireta);
    cmp({e.name, ".idsta"}, bus.out_idsta,               e.idsta);
    cmp({e.name, ".cpy"},   bus.out_cpy_data,            e.cpy);
    cmp({e.name, ".stall"}, 64'(bus.out_stall),          64'(e.stall));
    cmp({e.name, ".rv"},    64'(bus.out_redirect_valid), 64'(e.rv));
    cmp({e.name, ".rpc"},   bus.out_redirect_pc,         e.rpc);
    cmp({e.name, ".ack"},   64'(bus.out_irq_ack),        64'(e.ack));
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput();
  endtask

  initial begin
    bit       found;
    int       redirects;
    logic [63:0] seenPc;
    logic [3:0]  seenAck;

    bus.in_instr_valid = 1'b0; bus.in_is_iog1 = 1'b0; bus.in_oper = OP_NOP;
    bus.in_reg_data = '0; bus.in_next_pc = '0; bus.in_pipe_idle = 1'b0; bus.in_irq = '0;

    //                 name           rst v  g  oper         data   npc     pi irq       ie ireta    idsta    cpy      st rv rpc      ack
    vecs.push_back(mkVec("reset",       0, 0, 0, OP_NOP,      0,      0,      0, 4'b0000,  0, 0,       0,       0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rst_release", 1, 0, 0, OP_NOP,      0,      0,      1, 4'b0000,  0, 0,       0,       0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("wr_idsta",    1, 1, 1, OP_CIDSTA_W, 'h1003, 0,      1, 4'b0000,  0, 0,       0,       0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rd_idsta",    1, 1, 1, OP_CIDSTA_R, 0,      0,      1, 4'b0000,  0, 0,       'h1000,  'h1000,  0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("ei",          1, 1, 1, OP_EI,       0,      0,      1, 4'b0000,  0, 0,       'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("irq_seen",    1, 0, 0, OP_NOP,      0,      'h3000, 1, 4'b0110,  1, 0,       'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("drain",       1, 0, 0, OP_NOP,      0,      'h3000, 1, 4'b0110,  1, 0,       'h1000,  0,       1, 0, 0,       4'b0000));
    vecs.push_back(mkVec("vector",      1, 0, 0, OP_NOP,      0,      'h2004, 1, 4'b0110,  1, 0,       'h1000,  0,       1, 1, 'h1000,  4'b0010));
    vecs.push_back(mkVec("post_vector", 1, 0, 0, OP_NOP,      0,      'h2008, 1, 4'b0110,  0, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rd_ireta",    1, 1, 1, OP_CIRETA_R, 0,      0,      1, 4'b0000,  0, 'h2004,  'h1000,  'h2004,  0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("reti",        1, 1, 1, OP_RETI,     0,      0,      1, 4'b0000,  0, 'h2004,  'h1000,  0,       0, 1, 'h2004,  4'b0000));
    vecs.push_back(mkVec("after_reti",  1, 0, 0, OP_NOP,      0,      0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("irq_busy",    1, 0, 0, OP_NOP,      0,      0,      0, 4'b0001,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("drain_di",    1, 1, 1, OP_DI,       0,      0,      0, 4'b0001,  1, 'h2004,  'h1000,  0,       1, 0, 0,       4'b0000));
    vecs.push_back(mkVec("after_di",    1, 0, 0, OP_NOP,      0,      0,      0, 4'b0001,  0, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("ei2",         1, 1, 1, OP_EI,       0,      0,      1, 4'b0001,  0, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("irq_again",   1, 0, 0, OP_NOP,      0,      0,      0, 4'b0001,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("drain_drop",  1, 0, 0, OP_NOP,      0,      0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       1, 0, 0,       4'b0000));
    vecs.push_back(mkVec("spurious",    1, 0, 0, OP_NOP,      0,      'h5550, 1, 4'b0000,  1, 'h2004,  'h1000,  0,       1, 0, 0,       4'b0000));
    vecs.push_back(mkVec("after_spur",  1, 0, 0, OP_NOP,      0,      0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("di_blocks",   1, 1, 1, OP_DI,       0,      0,      1, 4'b1000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("idle_masked", 1, 0, 0, OP_NOP,      0,      0,      1, 4'b1000,  0, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("cpy_ie_w",    1, 1, 1, OP_CIE_W,    'h3,    0,      1, 4'b0000,  0, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rd_ie",       1, 1, 1, OP_CIE_R,    0,      0,      1, 4'b0000,  1, 'h2004,  'h1000,  1,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("bad_oper",    1, 1, 1, 4'hF,        'hFFFF, 0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("not_iog1",    1, 1, 0, OP_DI,       0,      0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("ireta_align", 1, 1, 1, OP_CIRETA_W, 'h43,   0,      1, 4'b0000,  1, 'h2004,  'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rd_ireta40",  1, 1, 1, OP_CIRETA_R, 0,      0,      1, 4'b0000,  1, 'h40,    'h1000,  'h40,    0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("irq_for_rst", 1, 0, 0, OP_NOP,      0,      0,      0, 4'b0100,  1, 'h40,    'h1000,  0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("drain2",      1, 0, 0, OP_NOP,      0,      0,      0, 4'b0100,  1, 'h40,    'h1000,  0,       1, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rst_mid",     0, 0, 0, OP_NOP,      0,      0,      1, 4'b0100,  0, 0,       0,       0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rst_hold",    0, 0, 0, OP_NOP,      0,      0,      1, 4'b0100,  0, 0,       0,       0,       0, 0, 0,       4'b0000));
    vecs.push_back(mkVec("rst_out",     1, 0, 0, OP_NOP,      0,      0,      1, 4'b0100,  0, 0,       0,       0,       0, 0, 0,       4'b0000));

    foreach (vecs[i]) runVec(vecs[i]);

    // Reti while draining aborts the entry but still redirects to ireta.
    runVec(mkVec("h_wr_idsta",  1, 1, 1, OP_CIDSTA_W, 'h1237, 0, 1, 4'b0000, 0, 0,    0,      0, 0, 0, 0,    4'b0000));
    runVec(mkVec("h_wr_ireta",  1, 1, 1, OP_CIRETA_W, 'h8B,   0, 1, 4'b0000, 0, 0,    'h1234, 0, 0, 0, 0,    4'b0000));
    runVec(mkVec("h_ei",        1, 1, 1, OP_EI,       0,      0, 1, 4'b0000, 0, 'h88, 'h1234, 0, 0, 0, 0,    4'b0000));
    runVec(mkVec("h_irq",       1, 0, 0, OP_NOP,      0,      0, 0, 4'b0001, 1, 'h88, 'h1234, 0, 0, 0, 0,    4'b0000));
    runVec(mkVec("h_reti_drn",  1, 1, 1, OP_RETI,     0,      0, 1, 4'b0001, 1, 'h88, 'h1234, 0, 1, 1, 'h88, 4'b0000));
    runVec(mkVec("h_after",     1, 0, 0, OP_NOP,      0,      0, 1, 4'b0000, 1, 'h88, 'h1234, 0, 0, 0, 0,    4'b0000));

    // Full entry with a busy pipe, waited on with a cycle budget.
    @(negedge clk);
    bus.in_instr_valid = 1'b0;
    bus.in_irq         = 4'b1000;
    bus.in_pipe_idle   = 1'b0;
    bus.in_next_pc     = 64'h7770;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      cmp("wait_stall", 64'(bus.out_stall), 64'd1);
    end
    bus.in_pipe_idle = 1'b1;
    found = 1'b0;
    redirects = 0;
    seenPc = '0;
    seenAck = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (bus.out_redirect_valid) begin
        redirects++;
        if (!found) begin
          found   = 1'b1;
          seenPc  = bus.out_redirect_pc;
          seenAck = bus.out_irq_ack;
        end
      end
    end
    cmp("vector_seen", 64'(found), 64'd1);
    cmp("vector_count", 64'(redirects), 64'd1);
    cmp("vector_pc", seenPc, 64'h1234);
    cmp("vector_ack", 64'(seenAck), 64'(4'b1000));
    cmp("entry_ie", 64'(bus.out_ie), 64'd0);
    cmp("entry_ireta", bus.out_ireta, 64'h7770);
    cmp("entry_stall", 64'(bus.out_stall), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
